// File: rtl/ptp_ts_pkg.sv
// Shared definitions for the PTP time-bus receive checker: field widths,
// nominal period/tolerance, FSM states and the 96-bit timestamp layout.
package ptp_ts_pkg;

  localparam int SEC_W = 48;
  localparam int NS_W  = 32;
  localparam int FNS_W = 16;
  localparam int FX_W  = NS_W + FNS_W;

  localparam logic [29:0] NS_PER_SEC = 30'd1000000000;
  localparam logic [3:0]  PERIOD_NS  = 4'd6;
  localparam logic [15:0] PERIOD_FNS = 16'h6666;
  localparam logic [15:0] TOL_FNS    = 16'h0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    TRACK = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
    logic [FNS_W-1:0] fns;
  } ts_t;

  // ns.fns as one unsigned fixed-point value in 1/65536 ns units
  function automatic logic [FX_W-1:0] ts_fx(input ts_t t);
    return {t.ns, t.fns};
  endfunction

endpackage

// File: rtl/ptp_ts_delta.sv
// Increment / rollover evaluation between two consecutive timestamps.
// All outputs are registered one cycle after the inputs.
module ptp_ts_delta
  import ptp_ts_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] i_s1,
  input  logic [95:0] i_prev,
  output logic        o_delta_ok,
  output logic        o_sec_ok,
  output logic        o_rollover,
  output logic        o_sec_inc
);

  localparam logic [FX_W-1:0] FX_SEC = {2'b00, NS_PER_SEC, 16'h0000};
  localparam logic [FX_W-1:0] FX_NOM = {28'd0, PERIOD_NS, PERIOD_FNS};
  localparam logic [FX_W-1:0] FX_LO  = FX_NOM - {32'd0, TOL_FNS};
  localparam logic [FX_W-1:0] FX_HI  = FX_NOM + {32'd0, TOL_FNS};

  ts_t             w_cur;
  ts_t             w_prv;
  logic            w_roll;
  logic [FX_W-1:0] w_delta;
  logic            w_sec_inc;
  logic            w_sec_ok;
  logic            w_ns_ok;
  logic            w_tol_ok;

  logic r_delta_ok;
  logic r_sec_ok;
  logic r_rollover;
  logic r_sec_inc;

  assign w_cur  = ts_t'(i_s1);
  assign w_prv  = ts_t'(i_prev);
  assign w_roll = (w_cur.ns < w_prv.ns);

  // Modular subtraction; adding one second of fixed-point ns undoes the wrap
  assign w_delta   = ts_fx(w_cur) - ts_fx(w_prv) + (w_roll ? FX_SEC : '0);
  assign w_tol_ok  = (w_delta >= FX_LO) && (w_delta <= FX_HI);
  assign w_ns_ok   = (w_cur.ns < {2'b00, NS_PER_SEC}) && (w_prv.ns < {2'b00, NS_PER_SEC});
  assign w_sec_inc = (w_cur.sec == w_prv.sec + 48'd1);
  assign w_sec_ok  = w_roll ? w_sec_inc : (w_cur.sec == w_prv.sec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delta_ok <= 1'b0;
      r_sec_ok   <= 1'b0;
      r_rollover <= 1'b0;
      r_sec_inc  <= 1'b0;
    end else begin
      r_delta_ok <= w_tol_ok && w_ns_ok;
      r_sec_ok   <= w_sec_ok;
      r_rollover <= w_roll;
      r_sec_inc  <= w_sec_inc;
    end
  end

  assign o_delta_ok = r_delta_ok;
  assign o_sec_ok   = r_sec_ok;
  assign o_rollover = r_rollover;
  assign o_sec_inc  = r_sec_inc;

endmodule

// File: rtl/ptp_ts_rx_check.sv
// PTP time-bus receive checker: continuity check, PPS regeneration, lock FSM
// and saturating error counters. PPS cross-check enabled by PTP_TS_RX_CHECK_PPS_EN.
module ptp_ts_rx_check
  import ptp_ts_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] ts_96,
  input  logic        ts_step,
  input  logic        pps,
  output logic        locked,
  output logic        pps_out,
  output logic        err_inc,
  output logic        err_pps,
  output logic [15:0] inc_err_count,
  output logic [15:0] pps_err_count,
  output logic [3:0]  dbg_status
);

  logic [95:0] r_s1;
  logic        r_s1_step;
  logic        r_s1_pps;
  logic        r_s1_vld;
  logic        r_pair_vld;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_delta_ok;
  logic        w_sec_ok;
  logic        w_rollover;
  logic        w_sec_inc;
  logic        w_good;
  logic        w_pps_cand;
  logic        w_pps;
  logic        w_err_inc;

  logic        r_pps_out;
  logic        r_err_inc;
  logic [15:0] r_inc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s1_step  <= 1'b0;
      r_s1_pps   <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_pair_vld <= 1'b0;
    end else begin
      r_s1       <= ts_96;
      r_s1_step  <= ts_step;
      r_s1_pps   <= pps;
      r_s1_vld   <= 1'b1;
      r_pair_vld <= r_s1_vld;
    end
  end

  // Fed one cycle early (next s1, current s1) so its registered flags describe
  // the pair currently held in s1/prev; prev itself then needs no storage here.
  ptp_ts_delta u_delta (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_s1       (ts_96),
    .i_prev     (r_s1),
    .o_delta_ok (w_delta_ok),
    .o_sec_ok   (w_sec_ok),
    .o_rollover (w_rollover),
    .o_sec_inc  (w_sec_inc)
  );

  assign w_good     = r_pair_vld && w_delta_ok && w_sec_ok;
  assign w_pps_cand = r_pair_vld && w_sec_inc && !r_s1_step;

`ifdef PTP_TS_RX_CHECK_PPS_EN
  logic        w_err_pps;
  logic        r_err_pps;
  logic [15:0] r_pps_cnt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pps       = 1'b0;
    w_err_inc   = 1'b0;
`ifdef PTP_TS_RX_CHECK_PPS_EN
    w_err_pps   = 1'b0;
`endif
    case (r_state)
      IDLE: w_state_nxt = LOCK;
      LOCK: begin
        w_pps = w_pps_cand;
        if (!r_s1_step && w_good) w_state_nxt = TRACK;
      end
      TRACK: begin
        w_pps = w_pps_cand;
        if (r_s1_step) begin
          w_state_nxt = LOCK;
        end else begin
`ifdef PTP_TS_RX_CHECK_PPS_EN
          w_err_pps = (w_pps_cand != r_s1_pps);
`endif
          if (!w_good) begin
            w_err_inc   = 1'b1;
            w_state_nxt = LOCK;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pps_out <= 1'b0;
      r_err_inc <= 1'b0;
      r_inc_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pps_out <= w_pps;
      r_err_inc <= w_err_inc;
      if (w_err_inc && (r_inc_cnt != 16'hFFFF)) r_inc_cnt <= r_inc_cnt + 16'd1;
    end
  end

`ifdef PTP_TS_RX_CHECK_PPS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pps <= 1'b0;
      r_pps_cnt <= '0;
    end else begin
      r_err_pps <= w_err_pps;
      if (w_err_pps && (r_pps_cnt != 16'hFFFF)) r_pps_cnt <= r_pps_cnt + 16'd1;
    end
  end

  assign err_pps       = r_err_pps;
  assign pps_err_count = r_pps_cnt;
`else
  assign err_pps       = 1'b0;
  assign pps_err_count = '0;
`endif

  assign locked        = (r_state == TRACK);
  assign pps_out       = r_pps_out;
  assign err_inc       = r_err_inc;
  assign inc_err_count = r_inc_cnt;
  assign dbg_status    = {w_rollover, r_s1_pps, r_state};

endmodule

// File: tb/tb_ptp_ts_rx_check.sv
// Self-checking bench for ptp_ts_rx_check: directed phases plus randomized
// timestamp streams checked against a behavioural model of the time-bus rules.
module tb_ptp_ts_rx_check;

  localparam longint NOM    = 64'h66666;
  localparam longint TOL    = 64'h100;
  localparam longint SEC_FX = 64'd1000000000 * 64'd65536;
`ifdef PTP_TS_RX_CHECK_PPS_EN
  localparam bit PPS_EN = 1'b1;
`else
  localparam bit PPS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [95:0] ts_96 = '0;
  logic        ts_step = 1'b0;
  logic        pps = 1'b0;
  logic        locked, pps_out, err_inc, err_pps;
  logic [15:0] inc_err_count, pps_err_count;
  logic [3:0]  dbg_status;

  ptp_ts_rx_check dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ts_96         (ts_96),
    .ts_step       (ts_step),
    .pps           (pps),
    .locked        (locked),
    .pps_out       (pps_out),
    .err_inc       (err_inc),
    .err_pps       (err_pps),
    .inc_err_count (inc_err_count),
    .pps_err_count (pps_err_count),
    .dbg_status    (dbg_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] fns;
    logic        step;
    logic        pps;
  } smp_t;

  typedef struct {
    logic        locked;
    logic        pps_out;
    logic        err_inc;
    logic        err_pps;
    logic [15:0] inc_cnt;
    logic [15:0] pps_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  bit   m_track;
  bit   m_have_prev;
  smp_t m_prev;
  int   m_inc_cnt;
  int   m_pps_cnt;

  // Source time generator
  logic [47:0] g_sec;
  longint      g_t;
  bit          g_pend;
  int          n_pps_seen;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_idle();
    exp_t e;
    e.locked = 1'b0; e.pps_out = 1'b0; e.err_inc = 1'b0; e.err_pps = 1'b0;
    e.inc_cnt = 16'(m_inc_cnt); e.pps_cnt = 16'(m_pps_cnt);
    exp_q.push_back(e);
  endtask

  // Outputs for 'cur' judged against the previous sample, due two cycles later
  task automatic model_push(input smp_t cur);
    exp_t   e;
    longint d, dev;
    bit     ok, pps_exp;
    e.pps_out = 1'b0; e.err_inc = 1'b0; e.err_pps = 1'b0;
    if (!m_have_prev || cur.step) begin
      m_track = 1'b0;
    end else begin
      d = longint'(cur.ns) * 65536 + longint'(cur.fns)
        - (longint'(m_prev.ns) * 65536 + longint'(m_prev.fns));
      if (cur.ns < m_prev.ns) begin
        d  = d + SEC_FX;
        ok = (cur.sec == m_prev.sec + 48'd1);
      end else begin
        ok = (cur.sec == m_prev.sec);
      end
      if (cur.ns >= 32'd1000000000 || m_prev.ns >= 32'd1000000000) ok = 1'b0;
      dev = d - NOM;
      if (dev < 0) dev = -dev;
      if (dev > TOL) ok = 1'b0;
      pps_exp   = (cur.sec == m_prev.sec + 48'd1);
      e.pps_out = pps_exp;
      if (m_track) begin
        if (PPS_EN && (pps_exp != cur.pps)) begin
          e.err_pps = 1'b1;
          if (m_pps_cnt < 65535) m_pps_cnt++;
        end
        if (!ok) begin
          e.err_inc = 1'b1;
          if (m_inc_cnt < 65535) m_inc_cnt++;
          m_track = 1'b0;
        end
      end else if (ok) begin
        m_track = 1'b1;
      end
    end
    e.locked  = m_track;
    e.inc_cnt = 16'(m_inc_cnt);
    e.pps_cnt = 16'(m_pps_cnt);
    m_prev      = cur;
    m_have_prev = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drive(input smp_t s);
    exp_t e;
    ts_96   = {s.sec, s.ns, s.fns};
    ts_step = s.step;
    pps     = s.pps;
    model_push(s);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("locked", 16'(locked), 16'(e.locked));
    chk("pps_out", 16'(pps_out), 16'(e.pps_out));
    chk("err_inc", 16'(err_inc), 16'(e.err_inc));
    chk("err_pps", 16'(err_pps), 16'(e.err_pps));
    chk("inc_err_count", inc_err_count, e.inc_cnt);
    chk("pps_err_count", pps_err_count, e.pps_cnt);
    if (pps_out === 1'b1) n_pps_seen++;
  endtask

  task automatic adv(input longint inc);
    g_t = g_t + inc;
    while (g_t >= SEC_FX) begin g_t = g_t - SEC_FX; g_sec = g_sec + 48'd1; end
    while (g_t < 0)       begin g_t = g_t + SEC_FX; g_sec = g_sec - 48'd1; end
  endtask

  function automatic smp_t mk(input bit step, input bit p);
    smp_t s;
    s.sec = g_sec; s.ns = 32'(g_t / 65536); s.fns = 16'(g_t % 65536);
    s.step = step; s.pps = p;
    return s;
  endfunction

  // mode 0: source pps with the rollover sample, 1: one cycle late, 2: never
  task automatic tick(input longint inc, input int mode);
    logic [47:0] old;
    bit rolled, p;
    old = g_sec;
    adv(inc);
    rolled = (g_sec == old + 48'd1);
    p = (mode == 0) ? rolled : (mode == 1) ? g_pend : 1'b0;
    g_pend = rolled;
    drive(mk(1'b0, p));
  endtask

  task automatic jump(input logic [47:0] sec, input longint t, input bit step);
    g_sec = sec; g_t = t; g_pend = 1'b0;
    drive(mk(step, 1'b0));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_pps_out", 16'(pps_out), 16'd0);
    chk("rst_err_inc", 16'(err_inc), 16'd0);
    chk("rst_err_pps", 16'(err_pps), 16'd0);
    chk("rst_inc_cnt", inc_err_count, 16'd0);
    chk("rst_pps_cnt", pps_err_count, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_track = 1'b0; m_have_prev = 1'b0; m_inc_cnt = 0; m_pps_cnt = 0;
    g_pend = 1'b0;
    push_idle();
  endtask

  initial begin
    longint dev;
    int     r, mode;
    smp_t   s;
    #2;

    // Steady ramp
    reset_dut();
    jump(48'd0, 0, 1'b0);
    repeat (100) tick(NOM, 0);
    chk("ramp_locked", 16'(locked), 16'd1);
    chk("ramp_inc_cnt", inc_err_count, 16'd0);

    // Second rollover with coincident source pps
    reset_dut();
    g_sec = 48'd5; g_t = 64'd999999996 * 65536;
    adv(-10 * NOM);
    jump(g_sec, g_t, 1'b0);
    n_pps_seen = 0;
    repeat (14) tick(NOM, 0);
    chk("roll_pps_pulses", 16'(n_pps_seen), 16'd1);
    chk("roll_pps_cnt", pps_err_count, 16'd0);

    // Bad increment, then relock
    reset_dut();
    jump(48'd3, 0, 1'b0);
    repeat (10) tick(NOM, 0);
    tick(64'd7 * 65536 + 64'h6666, 0);
    repeat (6) tick(NOM, 0);
    chk("bad_inc_cnt", inc_err_count, 16'd1);
    chk("bad_relock", 16'(locked), 16'd1);

    // Step to a new second
    n_pps_seen = 0;
    jump(48'd100, 0, 1'b1);
    repeat (6) tick(NOM, 0);
    chk("step_no_pps", 16'(n_pps_seen), 16'd0);
    chk("step_no_err", inc_err_count, 16'd1);
    chk("step_locked", 16'(locked), 16'd1);

    // Source pps one cycle late
    jump(48'd7, SEC_FX - 8 * NOM, 1'b1);
    repeat (12) tick(NOM, 1);
    chk("late_pps_cnt", pps_err_count, PPS_EN ? 16'd2 : 16'd0);

    // Randomized streams with a mid-stream reset
    reset_dut();
    jump(48'($urandom_range(1, 1000)), 0, 1'b0);
    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        reset_dut();
        jump(g_sec, g_t, 1'b0);
      end
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      if (i % 150 == 75) begin
        jump(48'($urandom_range(1, 1000)), SEC_FX - longint'($urandom_range(5, 40)) * NOM,
             1'b1);
      end else if (r < 3) begin
        jump(48'($urandom_range(1, 1000)),
             longint'($urandom_range(0, 999999999)) * 65536 + longint'($urandom_range(0, 65535)),
             1'b1);
      end else if (r < 6) begin
        s = mk(1'b0, 1'b0);
        s.ns = 32'd1000000000 + 32'($urandom_range(0, 50));
        drive(s);
      end else if (r < 10) begin
        dev = TOL + longint'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) dev = -dev;
        tick(NOM + dev, mode);
      end else if (r < 20) begin
        tick(NOM + longint'($urandom_range(0, 1024)) - 512, mode);
      end else begin
        tick(NOM + longint'($urandom_range(0, 510)) - 255, mode);
      end
    end

    // Counter saturation starting just below full scale
    reset_dut();
    force dut.r_inc_cnt = 16'hFFFC;
    #1;
    release dut.r_inc_cnt;
    m_inc_cnt = 16'hFFFC;
    exp_q[0].inc_cnt = 16'hFFFC;
    jump(48'd9, 0, 1'b0);
    repeat (3) tick(NOM, 0);
    for (int k = 0; k < 10; k++) begin
      tick(NOM + 64'h400, 0);
      tick(NOM, 0);
    end
    tick(NOM, 0);
    chk("sat_inc_cnt", inc_err_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
